// File: rtl/lsq_ring.sv
// lsq_ring: parametrised in-order load/store queue between decoder/ROB and
// the memory controller. Entries live in a DEPTH-deep circular buffer, snoop
// CDB_N result buses for missing operands and issue to memory from the head.
// Load results and store-ready tags are broadcast on the queue's own CDB port.
// Stores reach memory only after the ROB commit pulse.
//
// Optional feature macro: LSQ_ALLOC_BYPASS_EN
//   defined   : a not-ready operand at allocation captures a same-cycle CDB hit
//   undefined : the operand is stored waiting for a later broadcast
//
// Ports:
//   clk, rst_in (sync active-low), rdy_in (global stall), flush
//   alloc_*      : allocation request from decoder, alloc_full back-pressure
//   cdb_*        : snooped result buses (flattened, bus k at [k*W +: W])
//   store_commit : ROB commits the head store
//   mem_*        : request/response channel to the memory controller
//   out_*        : queue's own CDB broadcast
//   count        : current occupancy
module lsq_ring #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned TAG_W      = 5,
   parameter int unsigned CDB_N      = 2,
   parameter int unsigned FULL_SLACK = 1
) (
   input  logic                         clk,
   input  logic                         rst_in,
   input  logic                         rdy_in,
   input  logic                         flush,
   input  logic                         alloc_en,
   input  logic                         alloc_is_store,
   input  logic [2:0]                   alloc_funct3,
   input  logic [31:0]                  alloc_imm,
   input  logic [TAG_W-1:0]             alloc_tag,
   input  logic                         alloc_rs1_rdy,
   input  logic                         alloc_rs2_rdy,
   input  logic [31:0]                  alloc_rs1_val,
   input  logic [31:0]                  alloc_rs2_val,
   input  logic [TAG_W-1:0]             alloc_rs1_tag,
   input  logic [TAG_W-1:0]             alloc_rs2_tag,
   output logic                         alloc_full,
   input  logic [CDB_N-1:0]             cdb_valid,
   input  logic [CDB_N*TAG_W-1:0]       cdb_tag,
   input  logic [CDB_N*32-1:0]          cdb_val,
   input  logic                         store_commit,
   input  logic                         mem_busy,
   output logic                         mem_req_load,
   output logic                         mem_req_store,
   output logic [31:0]                  mem_addr,
   output logic [2:0]                   mem_funct3,
   output logic [31:0]                  mem_wdata,
   input  logic                         mem_rsp_valid,
   input  logic [31:0]                  mem_rsp_data,
   output logic                         out_valid,
   output logic [TAG_W-1:0]             out_tag,
   output logic [31:0]                  out_val,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LD_WAIT = 2'd1;
   localparam logic [1:0] S_ST_WAIT = 2'd2;

   // entry storage
   logic              r_valid    [DEPTH];
   logic              r_is_store [DEPTH];
   logic [2:0]        r_funct3   [DEPTH];
   logic [TAG_W-1:0]  r_tag      [DEPTH];
   logic [31:0]       r_imm      [DEPTH];
   logic [31:0]       r_base_val [DEPTH];
   logic              r_base_rdy [DEPTH];
   logic [TAG_W-1:0]  r_base_q   [DEPTH];
   logic [31:0]       r_data_val [DEPTH];
   logic              r_data_rdy [DEPTH];
   logic [TAG_W-1:0]  r_data_q   [DEPTH];
   logic              r_addr_rdy [DEPTH];
   logic [31:0]       r_addr     [DEPTH];

   logic [PTR_W-1:0]  r_head, r_tail;
   logic [CNT_W-1:0]  r_count;
   logic [1:0]        r_state;
   logic              r_commit_lat, r_drop_rsp;

   logic              r_mem_req_load, r_mem_req_store;
   logic [31:0]       r_mem_addr, r_mem_wdata;
   logic [2:0]        r_mem_funct3;
   logic              r_out_valid;
   logic [TAG_W-1:0]  r_out_tag;
   logic [31:0]       r_out_val;

   logic [1:0]        w_state_nxt;
   logic              w_issue_ld, w_issue_st, w_bcast_ld, w_bcast_st, w_pop;
   logic              w_head_ok, w_alloc_ok;
   logic              w_byp1_hit, w_byp2_hit;
   logic [31:0]       w_byp1_val, w_byp2_val;

   assign w_head_ok  = r_valid[r_head] && r_addr_rdy[r_head];
   assign w_alloc_ok = alloc_en && (r_count != CNT_W'(DEPTH));

   // head FSM next-state and per-cycle actions
   always_comb begin
      w_state_nxt = r_state;
      w_issue_ld  = 1'b0;
      w_issue_st  = 1'b0;
      w_bcast_ld  = 1'b0;
      w_bcast_st  = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_head_ok) begin
               if (!r_is_store[r_head]) begin
                  if (!mem_busy) begin
                     w_issue_ld  = 1'b1;
                     w_state_nxt = S_LD_WAIT;
                  end
               end else if (r_data_rdy[r_head]) begin
                  w_bcast_st  = 1'b1;
                  w_state_nxt = S_ST_WAIT;
               end
            end
         end
         S_LD_WAIT: begin
            // a response owed to a flushed load is swallowed first
            if (mem_rsp_valid && !r_drop_rsp) begin
               w_bcast_ld  = 1'b1;
               w_pop       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_ST_WAIT: begin
            if ((store_commit || r_commit_lat) && !mem_busy) begin
               w_issue_st  = 1'b1;
               w_pop       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // allocation-time capture of a same-cycle CDB result (lowest bus wins)
   always_comb begin
      w_byp1_hit = 1'b0;
      w_byp1_val = 32'd0;
      w_byp2_hit = 1'b0;
      w_byp2_val = 32'd0;
`ifdef LSQ_ALLOC_BYPASS_EN
      for (int k = int'(CDB_N) - 1; k >= 0; k--) begin
         if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == alloc_rs1_tag) begin
            w_byp1_hit = 1'b1;
            w_byp1_val = cdb_val[k*32 +: 32];
         end
         if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == alloc_rs2_tag) begin
            w_byp2_hit = 1'b1;
            w_byp2_val = cdb_val[k*32 +: 32];
         end
      end
`endif
   end

   // state, entries and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_in) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_valid[i]    <= 1'b0;
            r_base_rdy[i] <= 1'b0;
            r_data_rdy[i] <= 1'b0;
            r_addr_rdy[i] <= 1'b0;
         end
         r_head          <= '0;
         r_tail          <= '0;
         r_count         <= '0;
         r_state         <= S_IDLE;
         r_commit_lat    <= 1'b0;
         r_drop_rsp      <= 1'b0;
         r_mem_req_load  <= 1'b0;
         r_mem_req_store <= 1'b0;
         r_mem_addr      <= '0;
         r_mem_funct3    <= '0;
         r_mem_wdata     <= '0;
         r_out_valid     <= 1'b0;
         r_out_tag       <= '0;
         r_out_val       <= '0;
      end else if (!rdy_in) begin
         r_mem_req_load  <= 1'b0;
         r_mem_req_store <= 1'b0;
      end else begin
         r_mem_req_load  <= 1'b0;
         r_mem_req_store <= 1'b0;
         r_out_valid     <= 1'b0;
         if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) r_valid[i] <= 1'b0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_state      <= S_IDLE;
            r_commit_lat <= 1'b0;
            // an outstanding load response must not reach the CDB
            r_drop_rsp   <= !mem_rsp_valid && (r_drop_rsp || r_state == S_LD_WAIT);
         end else begin
            r_state <= w_state_nxt;
            if (r_drop_rsp && mem_rsp_valid) r_drop_rsp <= 1'b0;

            if (w_issue_st)
               r_commit_lat <= 1'b0;
            else if (r_state == S_ST_WAIT && store_commit && mem_busy)
               r_commit_lat <= 1'b1;

            // operand snoop; descending loop lets the lowest bus win
            for (int i = 0; i < int'(DEPTH); i++) begin
               for (int k = int'(CDB_N) - 1; k >= 0; k--) begin
                  if (r_valid[i] && cdb_valid[k]) begin
                     if (!r_base_rdy[i] && cdb_tag[k*TAG_W +: TAG_W] == r_base_q[i]) begin
                        r_base_rdy[i] <= 1'b1;
                        r_base_val[i] <= cdb_val[k*32 +: 32];
                     end
                     if (!r_data_rdy[i] && cdb_tag[k*TAG_W +: TAG_W] == r_data_q[i]) begin
                        r_data_rdy[i] <= 1'b1;
                        r_data_val[i] <= cdb_val[k*32 +: 32];
                     end
                  end
               end
               if (r_valid[i] && r_base_rdy[i] && !r_addr_rdy[i]) begin
                  r_addr[i]     <= r_base_val[i] + r_imm[i];
                  r_addr_rdy[i] <= 1'b1;
               end
            end

            if (w_alloc_ok) begin
               r_valid[r_tail]    <= 1'b1;
               r_is_store[r_tail] <= alloc_is_store;
               r_funct3[r_tail]   <= alloc_funct3;
               r_tag[r_tail]      <= alloc_tag;
               r_imm[r_tail]      <= alloc_imm;
               r_base_rdy[r_tail] <= alloc_rs1_rdy || w_byp1_hit;
               r_base_val[r_tail] <= alloc_rs1_rdy ? alloc_rs1_val : w_byp1_val;
               r_base_q[r_tail]   <= alloc_rs1_tag;
               r_data_rdy[r_tail] <= alloc_is_store ? (alloc_rs2_rdy || w_byp2_hit) : 1'b1;
               r_data_val[r_tail] <= !alloc_is_store ? 32'd0 :
                                     (alloc_rs2_rdy ? alloc_rs2_val : w_byp2_val);
               r_data_q[r_tail]   <= alloc_rs2_tag;
               r_addr_rdy[r_tail] <= 1'b0;
               r_tail             <= r_tail + PTR_W'(1);
            end

            if (w_pop) begin
               r_valid[r_head] <= 1'b0;
               r_head          <= r_head + PTR_W'(1);
            end

            if (w_alloc_ok && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_alloc_ok && w_pop) r_count <= r_count - CNT_W'(1);

            if (w_issue_ld || w_issue_st) begin
               r_mem_req_load  <= w_issue_ld;
               r_mem_req_store <= w_issue_st;
               r_mem_addr      <= r_addr[r_head];
               r_mem_funct3    <= r_funct3[r_head];
               if (w_issue_st) r_mem_wdata <= r_data_val[r_head];
            end

            if (w_bcast_ld || w_bcast_st) begin
               r_out_valid <= 1'b1;
               r_out_tag   <= r_tag[r_head];
               r_out_val   <= w_bcast_ld ? mem_rsp_data : 32'd0;
            end
         end
      end
   end

   // allocation into a full queue is a decoder bug
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_in)
      !(rdy_in && !flush && alloc_en && r_count == CNT_W'(DEPTH)));

   assign alloc_full    = (r_count >= CNT_W'(DEPTH - FULL_SLACK));
   assign count         = r_count;
   assign mem_req_load  = r_mem_req_load;
   assign mem_req_store = r_mem_req_store;
   assign mem_addr      = r_mem_addr;
   assign mem_funct3    = r_mem_funct3;
   assign mem_wdata     = r_mem_wdata;
   assign out_valid     = r_out_valid;
   assign out_tag       = r_out_tag;
   assign out_val       = r_out_val;

endmodule

// File: tb/tb_lsq_ring.sv
// Directed self-checking bench for lsq_ring (DEPTH=4, FULL_SLACK=1, CDB_N=2).
module tb_lsq_ring;
   localparam int unsigned DEPTH      = 4;
   localparam int unsigned TAG_W      = 5;
   localparam int unsigned CDB_N      = 2;
   localparam int unsigned FULL_SLACK = 1;
   localparam int unsigned CNT_W      = $clog2(DEPTH+1);

   logic                   clk;
   logic                   rst_in, rdy_in, flush;
   logic                   alloc_en, alloc_is_store;
   logic [2:0]             alloc_funct3;
   logic [31:0]            alloc_imm;
   logic [TAG_W-1:0]       alloc_tag;
   logic                   alloc_rs1_rdy, alloc_rs2_rdy;
   logic [31:0]            alloc_rs1_val, alloc_rs2_val;
   logic [TAG_W-1:0]       alloc_rs1_tag, alloc_rs2_tag;
   logic                   alloc_full;
   logic [CDB_N-1:0]       cdb_valid;
   logic [CDB_N*TAG_W-1:0] cdb_tag;
   logic [CDB_N*32-1:0]    cdb_val;
   logic                   store_commit, mem_busy;
   logic                   mem_req_load, mem_req_store;
   logic [31:0]            mem_addr, mem_wdata;
   logic [2:0]             mem_funct3;
   logic                   mem_rsp_valid;
   logic [31:0]            mem_rsp_data;
   logic                   out_valid;
   logic [TAG_W-1:0]       out_tag;
   logic [31:0]            out_val;
   logic [CNT_W-1:0]       count;

   int n_cmp = 0;
   int n_err = 0;

   lsq_ring #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CDB_N(CDB_N), .FULL_SLACK(FULL_SLACK)) dut (
      .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
      .alloc_en(alloc_en), .alloc_is_store(alloc_is_store), .alloc_funct3(alloc_funct3),
      .alloc_imm(alloc_imm), .alloc_tag(alloc_tag),
      .alloc_rs1_rdy(alloc_rs1_rdy), .alloc_rs2_rdy(alloc_rs2_rdy),
      .alloc_rs1_val(alloc_rs1_val), .alloc_rs2_val(alloc_rs2_val),
      .alloc_rs1_tag(alloc_rs1_tag), .alloc_rs2_tag(alloc_rs2_tag),
      .alloc_full(alloc_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .store_commit(store_commit), .mem_busy(mem_busy),
      .mem_req_load(mem_req_load), .mem_req_store(mem_req_store),
      .mem_addr(mem_addr), .mem_funct3(mem_funct3), .mem_wdata(mem_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .out_valid(out_valid), .out_tag(out_tag), .out_val(out_val), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // sel: 0 mem_req_load, 1 mem_req_store, 2 out_valid; bounded by max cycles
   task automatic wait_pulse(input int sel, input int max, input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         tick();
         case (sel)
            0:       seen = mem_req_load;
            1:       seen = mem_req_store;
            default: seen = out_valid;
         endcase
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   task automatic alloc_set(input logic st, input logic [31:0] imm, input logic [TAG_W-1:0] tag,
                            input logic r1_rdy, input logic [31:0] r1_val, input logic [TAG_W-1:0] r1_tag,
                            input logic r2_rdy, input logic [31:0] r2_val, input logic [TAG_W-1:0] r2_tag);
      alloc_en       = 1'b1;
      alloc_is_store = st;
      alloc_funct3   = 3'b010;
      alloc_imm      = imm;
      alloc_tag      = tag;
      alloc_rs1_rdy  = r1_rdy;
      alloc_rs1_val  = r1_val;
      alloc_rs1_tag  = r1_tag;
      alloc_rs2_rdy  = r2_rdy;
      alloc_rs2_val  = r2_val;
      alloc_rs2_tag  = r2_tag;
   endtask

   initial begin
      int a;
      int exp_cnt;
      logic seen;

      rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
      alloc_en = 1'b0; alloc_is_store = 1'b0; alloc_funct3 = 3'd0; alloc_imm = 32'd0;
      alloc_tag = '0; alloc_rs1_rdy = 1'b0; alloc_rs2_rdy = 1'b0;
      alloc_rs1_val = 32'd0; alloc_rs2_val = 32'd0; alloc_rs1_tag = '0; alloc_rs2_tag = '0;
      cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
      store_commit = 1'b0; mem_busy = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
      tick(); tick();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_full", 32'(alloc_full), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_req_load", 32'(mem_req_load), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      rst_in = 1'b1;

      // stall: allocation must be held off
      rdy_in = 1'b0;
      alloc_set(1'b0, 32'd4, 5'd1, 1'b1, 32'h1000, 5'd0, 1'b0, 32'd0, 5'd0);
      tick();
      chk("stall_count", 32'(count), 32'd0);
      rdy_in = 1'b1;

      // basic load
      tick();
      alloc_en = 1'b0;
      chk("ld_count", 32'(count), 32'd1);
      wait_pulse(0, 6, "ld_req");
      chk("ld_addr", mem_addr, 32'h1004);
      chk("ld_funct3", 32'(mem_funct3), 32'd2);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
      tick();
      mem_rsp_valid = 1'b0;
      chk("ld_out_valid", 32'(out_valid), 32'd1);
      chk("ld_out_tag", 32'(out_tag), 32'd1);
      chk("ld_out_val", out_val, 32'hDEADBEEF);
      chk("ld_count_after", 32'(count), 32'd0);
      chk("ld_req_pulse", 32'(mem_req_load), 32'd0);

      // store waiting on data from bus 1
      alloc_set(1'b1, 32'd0, 5'd2, 1'b1, 32'h2000, 5'd0, 1'b0, 32'd0, 5'd7);
      tick();
      alloc_en = 1'b0;
      tick(); tick(); tick();
      chk("st_hold", 32'(out_valid), 32'd0);
      cdb_valid = 2'b11; cdb_tag = {5'd7, 5'd9}; cdb_val = {32'h55, 32'h99};
      tick();
      cdb_valid = '0;
      wait_pulse(2, 4, "st_bcast");
      chk("st_out_tag", 32'(out_tag), 32'd2);
      chk("st_out_val", out_val, 32'd0);
      store_commit = 1'b1;
      tick();
      store_commit = 1'b0;
      chk("st_req", 32'(mem_req_store), 32'd1);
      chk("st_wdata", mem_wdata, 32'h55);
      chk("st_addr", mem_addr, 32'h2000);
      chk("st_count", 32'(count), 32'd0);

      // duplicate tag on both buses, then commit under mem_busy
      alloc_set(1'b1, 32'd8, 5'd3, 1'b1, 32'h3000, 5'd0, 1'b0, 32'd0, 5'd8);
      tick();
      alloc_en = 1'b0;
      cdb_valid = 2'b11; cdb_tag = {5'd8, 5'd8}; cdb_val = {32'h22, 32'h11};
      tick();
      cdb_valid = '0;
      wait_pulse(2, 4, "bz_bcast");
      chk("bz_out_tag", 32'(out_tag), 32'd3);
      mem_busy = 1'b1; store_commit = 1'b1;
      tick();
      store_commit = 1'b0;
      chk("bz_req_c1", 32'(mem_req_store), 32'd0);
      tick();
      chk("bz_req_c2", 32'(mem_req_store), 32'd0);
      tick();
      chk("bz_req_c3", 32'(mem_req_store), 32'd0);
      mem_busy = 1'b0;
      tick();
      chk("bz_req", 32'(mem_req_store), 32'd1);
      chk("bz_addr", mem_addr, 32'h3008);
      chk("bz_wdata_bus0", mem_wdata, 32'h11);
      tick();
      chk("bz_req_once", 32'(mem_req_store), 32'd0);

      // fill, full flag, pop+alloc and pointer wrap over 10 allocations
      mem_busy = 1'b1;
      for (int n = 0; n < 3; n++) begin
         alloc_set(1'b0, 32'(n*4), 5'(10+n), 1'b1, 32'h4000 + 32'(n*16), 5'd0, 1'b0, 32'd0, 5'd0);
         tick();
         if (n == 1) begin
            chk("fill_count2", 32'(count), 32'd2);
            chk("fill_full2", 32'(alloc_full), 32'd0);
         end
      end
      alloc_en = 1'b0;
      chk("fill_count3", 32'(count), 32'd3);
      chk("fill_full3", 32'(alloc_full), 32'd1);
      tick(); tick();
      chk("fill_busy_noreq", 32'(mem_req_load), 32'd0);
      mem_busy = 1'b0;
      a = 3;
      exp_cnt = 3;
      for (int h = 0; h < 10; h++) begin
         wait_pulse(0, 8, "wrap_req");
         chk("wrap_addr", mem_addr, 32'h4000 + 32'(h*20));
         mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA000 + 32'(h);
         if (a < 10) begin
            alloc_set(1'b0, 32'(a*4), 5'(10+a), 1'b1, 32'h4000 + 32'(a*16), 5'd0, 1'b0, 32'd0, 5'd0);
            a++;
         end else begin
            exp_cnt--;
         end
         tick();
         mem_rsp_valid = 1'b0; alloc_en = 1'b0;
         chk("wrap_out_valid", 32'(out_valid), 32'd1);
         chk("wrap_out_tag", 32'(out_tag), 32'(10+h));
         chk("wrap_out_val", out_val, 32'hA000 + 32'(h));
         chk("wrap_count", 32'(count), 32'(exp_cnt));
      end

      // flush during LD_WAIT
      alloc_set(1'b0, 32'd0, 5'd5, 1'b1, 32'h5000, 5'd0, 1'b0, 32'd0, 5'd0);
      tick();
      alloc_en = 1'b0;
      wait_pulse(0, 6, "fl_req");
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_count", 32'(count), 32'd0);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234;
      tick();
      mem_rsp_valid = 1'b0;
      chk("fl_drop", 32'(out_valid), 32'd0);
      tick();
      chk("fl_drop2", 32'(out_valid), 32'd0);
      alloc_set(1'b0, 32'h10, 5'd6, 1'b1, 32'h6000, 5'd0, 1'b0, 32'd0, 5'd0);
      tick();
      alloc_en = 1'b0;
      wait_pulse(0, 6, "fl_new_req");
      chk("fl_new_addr", mem_addr, 32'h6010);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h777;
      tick();
      mem_rsp_valid = 1'b0;
      chk("fl_new_valid", 32'(out_valid), 32'd1);
      chk("fl_new_tag", 32'(out_tag), 32'd6);
      chk("fl_new_val", out_val, 32'h777);

      // allocation coincident with a CDB result for the same tag
      alloc_set(1'b0, 32'h20, 5'd4, 1'b0, 32'd0, 5'd3, 1'b0, 32'd0, 5'd0);
      cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd3}; cdb_val = {32'h0, 32'h200};
      tick();
      alloc_en = 1'b0; cdb_valid = '0;
`ifdef LSQ_ALLOC_BYPASS_EN
      wait_pulse(0, 6, "byp_req");
      chk("byp_addr", mem_addr, 32'h220);
`else
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (mem_req_load) seen = 1'b1;
      end
      chk("nobyp_wait", 32'(seen), 32'd0);
      cdb_valid = 2'b10; cdb_tag = {5'd3, 5'd0}; cdb_val = {32'h300, 32'h0};
      tick();
      cdb_valid = '0;
      wait_pulse(0, 6, "nobyp_req");
      chk("nobyp_addr", mem_addr, 32'h320);
`endif
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE;
      tick();
      mem_rsp_valid = 1'b0;
      chk("byp_out_tag", 32'(out_tag), 32'd4);
      chk("byp_out_val", out_val, 32'hCAFE);
      chk("byp_count", 32'(count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
